// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // D grants allowed back-to-back while a fetch waits
    localparam int DEFAULT_MAX_DSTREAK = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory requesters, the arbiter and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch requester
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_kill;
    logic [DATA_WIDTH-1:0]   if_rdata;
    logic                    if_valid;
    // data requester
    logic                    d_req;
    logic                    d_we;
    logic [DATA_WIDTH/8-1:0] d_be;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_valid;
    // memory side
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    // hazard unit
    logic                    stall_if;
    logic                    stall_mem;

    // arbiter view
    modport slave (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_valid,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_valid,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall_if, stall_mem
    );

    // environment view: requesters plus memory
    modport master (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_valid,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port I/D memory between fetch and MEM stage.
// One transaction in flight; D wins ties unless fetch has been starved.
//
// state | meaning
// IDLE  | no transaction; pick a requester and latch its fields
// REQ   | mem_req held with stable fields until mem_gnt
// WAIT  | request accepted; waiting for mem_rvalid
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DSTREAK = DEFAULT_MAX_DSTREAK
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    state_e                  r_state;
    state_e                  w_state_nxt;
    owner_e                  r_owner;
    logic                    r_killed;
    logic [SW-1:0]           r_dstreak;

    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [DATA_WIDTH/8-1:0] r_mem_be;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    logic                    w_if_live;
    logic                    w_at_max;
    logic                    w_grant_d;
    logic                    w_grant_if;
    logic                    w_if_valid;
    logic                    w_d_valid;

    // A fetch being flushed this cycle is not a contender, so it cannot
    // block D through the starvation rule either.
    assign w_if_live  = bus.if_req & ~bus.if_kill;
    assign w_at_max   = (r_dstreak == STREAK_MAX);
    assign w_grant_d  = (r_state == IDLE) & bus.d_req & ~(w_if_live & w_at_max);
    assign w_grant_if = (r_state == IDLE) & ~w_grant_d & w_if_live;

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_d || w_grant_if) w_state_nxt = REQ;
            REQ:     if (bus.mem_gnt)             w_state_nxt = WAIT;
            WAIT:    if (bus.mem_rvalid)          w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    // owner, kill tracking, starvation streak and latched request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_NONE;
            r_killed    <= 1'b0;
            r_dstreak   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner     <= OWN_D;
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.d_we;
                r_mem_be    <= bus.d_be;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                if (!bus.if_req) begin
                    r_dstreak <= '0;
                end else if (!w_at_max) begin
                    r_dstreak <= r_dstreak + SW'(1);
                end
            end else if (w_grant_if) begin
                r_owner     <= OWN_IF;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
                r_dstreak   <= '0;
            end

            if (r_state == REQ && bus.mem_gnt) begin
                r_mem_req <= 1'b0;
            end

            if (r_state == WAIT && bus.mem_rvalid) begin
                r_owner  <= OWN_NONE;
                r_killed <= 1'b0;
            end else if (r_owner == OWN_IF && bus.if_kill &&
                         (r_state == REQ || r_state == WAIT)) begin
                r_killed <= 1'b1;
            end
        end
    end

    // response steering and stall requests
    always_comb begin
        w_d_valid     = bus.mem_rvalid & (r_owner == OWN_D);
        w_if_valid    = bus.mem_rvalid & (r_owner == OWN_IF) & ~r_killed & ~bus.if_kill;
        bus.d_valid   = w_d_valid;
        bus.if_valid  = w_if_valid;
        bus.d_rdata   = w_d_valid  ? bus.mem_rdata : '0;
        bus.if_rdata  = w_if_valid ? bus.mem_rdata : '0;
        bus.stall_if  = bus.if_req & ~w_if_valid & ~bus.if_kill;
        bus.stall_mem = bus.d_req & ~w_d_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory responder and scoreboard.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_d;
        bit          drop;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_DSTREAK(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    txn_t exp_q[$];
    int   gnt_delay = 0;
    int   rv_delay  = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk_if(input logic [31:0] addr, input logic [31:0] rdata, input bit drop);
        txn_t t;
        t.is_d = 1'b0; t.drop = drop; t.we = 1'b0; t.be = 4'hF;
        t.addr = addr; t.wdata = 32'h0; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t mk_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.is_d = 1'b1; t.drop = 1'b0; t.we = we; t.be = be;
        t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    // memory model: checks each request against the scoreboard head,
    // grants after gnt_delay cycles, answers rv_delay cycles after grant
    initial begin
        txn_t cur;
        int   rv_cnt   = 0;
        int   wait_cnt = 0;
        bit   fire;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        cur = mk_if(32'h0, 32'h0, 1'b0);
        forever begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            fire = 1'b0;
            if (!rst_n) begin
                rv_cnt   = 0;
                wait_cnt = 0;
            end else if (rv_cnt > 0) begin
                chk("req_dropped_after_gnt", 32'(bus.mem_req), 32'd0);
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = cur.rdata;
                    fire = 1'b1;
                end
            end else if (bus.mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 32'(bus.mem_req), 32'd0);
                end else begin
                    chk("req_addr",  bus.mem_addr,         exp_q[0].addr);
                    chk("req_we",    32'(bus.mem_we),      32'(exp_q[0].we));
                    chk("req_be",    32'(bus.mem_be),      32'(exp_q[0].be));
                    chk("req_wdata", bus.mem_wdata,        exp_q[0].wdata);
                    if (wait_cnt == gnt_delay) begin
                        bus.mem_gnt = 1'b1;
                        cur      = exp_q.pop_front();
                        rv_cnt   = rv_delay;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            if (fire) begin
                #2;
                chk("rsp_d_valid",  32'(bus.d_valid),  32'(cur.is_d));
                chk("rsp_if_valid", 32'(bus.if_valid), 32'(!cur.is_d && !cur.drop));
                chk("rsp_d_rdata",  bus.d_rdata,  cur.is_d ? cur.rdata : 32'h0);
                chk("rsp_if_rdata", bus.if_rdata, (!cur.is_d && !cur.drop) ? cur.rdata : 32'h0);
            end
        end
    end

    task automatic wait_valid(input bit is_d, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            #2;
            hit = is_d ? bus.d_valid : bus.if_valid;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        chk({tag, "_mem_be"},    32'(bus.mem_be),    32'd0);
        chk({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        chk({tag, "_if_valid"},  32'(bus.if_valid),  32'd0);
        chk({tag, "_d_valid"},   32'(bus.d_valid),   32'd0);
        chk({tag, "_stall_if"},  32'(bus.stall_if),  32'd0);
        chk({tag, "_stall_mem"}, 32'(bus.stall_mem), 32'd0);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_kill = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single fetch, 3-cycle latency
        @(negedge clk);
        exp_q.push_back(mk_if(32'h10, 32'h00500093, 1'b0));
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        #2 chk("t1_stall_c1", 32'(bus.stall_if), 32'd1);
        chk("t1_memreq_c1", 32'(bus.mem_req), 32'd0);
        @(negedge clk); #2;
        chk("t1_memreq_c2", 32'(bus.mem_req), 32'd1);
        chk("t1_stall_c2", 32'(bus.stall_if), 32'd1);
        @(negedge clk); #2;
        chk("t1_valid_c3", 32'(bus.if_valid), 32'd1);
        chk("t1_rdata_c3", bus.if_rdata, 32'h00500093);
        chk("t1_stall_c3", 32'(bus.stall_if), 32'd0);
        @(negedge clk);
        bus.if_req = 1'b0;

        // simultaneous requests: D first, IF right after
        @(negedge clk);
        exp_q.push_back(mk_d(1'b0, 4'hF, 32'h100, 32'h0, 32'hD000_0100));
        exp_q.push_back(mk_if(32'h14, 32'h00A00113, 1'b0));
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h100; bus.d_wdata = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        #2 chk("t2_stall_mem_start", 32'(bus.stall_mem), 32'd1);
        @(negedge clk); #2;
        chk("t2_d_first_addr", bus.mem_addr, 32'h100);
        wait_valid(1'b1, "t2_d_valid");
        chk("t2_stall_mem_fall", 32'(bus.stall_mem), 32'd0);
        chk("t2_stall_if_held", 32'(bus.stall_if), 32'd1);
        @(negedge clk);
        bus.d_req = 1'b0;
        #2 chk("t2_idle_gap", 32'(bus.mem_req), 32'd0);
        @(negedge clk); #2;
        chk("t2_if_issue_req", 32'(bus.mem_req), 32'd1);
        chk("t2_if_issue_addr", bus.mem_addr, 32'h14);
        wait_valid(1'b0, "t2_if_valid");
        chk("t2_if_rdata", bus.if_rdata, 32'h00A00113);
        @(negedge clk);
        bus.if_req = 1'b0;

        // starvation limit: D,D,D,D,IF,D then IF; streak cleared by the IF grant
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_d(1'b0, 4'hF, 32'h200 + 32'(4 * i), 32'h0, 32'hD000_0200 + 32'(4 * i)));
        exp_q.push_back(mk_if(32'h18, 32'h00000013, 1'b0));
        exp_q.push_back(mk_d(1'b0, 4'hF, 32'h210, 32'h0, 32'hD000_0210));
        exp_q.push_back(mk_if(32'h1C, 32'h00100073, 1'b0));
        bus.d_req = 1'b1; bus.d_addr = 32'h200;
        bus.if_req = 1'b1; bus.if_addr = 32'h18;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(1'b1, "t3_d_streak");
            @(negedge clk);
            bus.d_addr = 32'h200 + 32'(4 * i);
        end
        wait_valid(1'b0, "t3_if_forced");
        @(negedge clk);
        bus.if_addr = 32'h1C;
        wait_valid(1'b1, "t3_d_after_if");
        @(negedge clk);
        bus.d_req = 1'b0;
        wait_valid(1'b0, "t3_if_second");
        @(negedge clk);
        bus.if_req = 1'b0;

        // kill during WAIT; response dropped, new PC served afterwards
        @(negedge clk);
        rv_delay = 3;
        exp_q.push_back(mk_if(32'h20, 32'hBAD0_0020, 1'b1));
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        @(negedge clk); #2;
        chk("t4_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        bus.if_kill = 1'b1; bus.if_req = 1'b0;
        #2 chk("t4_kill_stall", 32'(bus.stall_if), 32'd0);
        @(negedge clk);
        bus.if_kill = 1'b0;
        exp_q.push_back(mk_if(32'h40, 32'h00208233, 1'b0));
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        #2 chk("t4_newpc_stall", 32'(bus.stall_if), 32'd1);
        @(negedge clk); #2;
        chk("t4_dropped_rvalid", 32'(bus.mem_rvalid), 32'd1);
        chk("t4_dropped_valid", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        rv_delay = 1;
        #2 chk("t4_idle_after_kill", 32'(bus.mem_req), 32'd0);
        wait_valid(1'b0, "t4_newpc_valid");
        chk("t4_newpc_rdata", bus.if_rdata, 32'h00208233);
        @(negedge clk);
        bus.if_req = 1'b0;

        // store with grant held off 4 cycles
        @(negedge clk);
        gnt_delay = 4;
        exp_q.push_back(mk_d(1'b1, 4'b0011, 32'h300, 32'hDEADBEEF, 32'h0));
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h300; bus.d_wdata = 32'hDEADBEEF;
        #2 chk("t5_stall_mem", 32'(bus.stall_mem), 32'd1);
        wait_valid(1'b1, "t5_store_ack");
        @(negedge clk);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_wdata = 32'h0;
        gnt_delay = 0;

        // reset in WAIT, then a fresh fetch
        @(negedge clk);
        rv_delay = 5;
        exp_q.push_back(mk_if(32'h50, 32'hBAD0_0050, 1'b0));
        bus.if_req = 1'b1; bus.if_addr = 32'h50;
        @(negedge clk); #2;
        chk("t6_req_addr", bus.mem_addr, 32'h50);
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.if_req = 1'b0;
        #1 chk_all_zero("t6_async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rv_delay = 1;
        exp_q.push_back(mk_if(32'h54, 32'h00C00193, 1'b0));
        bus.if_req = 1'b1; bus.if_addr = 32'h54;
        wait_valid(1'b0, "t6_fresh_valid");
        chk("t6_fresh_rdata", bus.if_rdata, 32'h00C00193);
        @(negedge clk);
        bus.if_req = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
